// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types for the 3-digit BCD countdown timer.
// Holds the FSM state enum, BCD digit type and clamp helper.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      EXPIRED
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   typedef struct packed {
      bcd_t h;
      bcd_t t;
      bcd_t u;
   } bcd3_t;

   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one registered BCD decade with load and borrow chain.
// Loads clamp to 9; a decrement from 0 wraps to 9 and raises borrow_out.
module bcd_down_digit
   import countdown_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec_in,
   output logic [3:0] digit,
   output logic       borrow_out
);

   assign borrow_out = dec_in && (digit == 4'd0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= bcd_clamp(load_val);
      end else if (dec_in) begin
         digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: 3-digit BCD countdown, IDLE/RUN/PAUSE/EXPIRED FSM.
// Define COUNTDOWN_ALARM_BLINK_EN to blink ALARM every PRESCALE/2 cycles.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int PRESCALE = 100000000
)
(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       START_STOP,
   input  logic       LOAD,
   input  logic [3:0] LOAD_UNITS,
   input  logic [3:0] LOAD_TENS,
   input  logic [3:0] LOAD_HUNDREDS,
   output logic [3:0] units,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic       RUNNING,
   output logic       ALARM
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   state_t        state;
   logic [PW-1:0] presc;
   bcd3_t         preset;
   bcd3_t         ld_req;
   bcd3_t         load_val;
   logic          presc_end;
   logic          cnt_nz;
   logic          cnt_last;
   logic          tick;
   logic          load_en;
   logic          b_u;
   logic          b_t;
   logic          b_h;
   logic          expire;

   assign ld_req    = {LOAD_HUNDREDS, LOAD_TENS, LOAD_UNITS};
   assign presc_end = (presc == PW'(PRESCALE - 1));
   assign cnt_nz    = |{hundreds, tens, units};
   assign cnt_last  = (hundreds == 4'd0) && (tens == 4'd0)
                   && (units == 4'd1);
   // Gating on a non-zero count keeps the chain from wrapping below 000.
   assign tick      = (state == RUN) && presc_end && cnt_nz;
   assign expire    = tick && (cnt_last || b_h);
   assign load_en   = LOAD || ((state == EXPIRED) && START_STOP);
   assign load_val  = LOAD ? ld_req : preset;

   bcd_down_digit u_units (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val.u),
      .dec_in     (tick),
      .digit      (units),
      .borrow_out (b_u)
   );

   bcd_down_digit u_tens (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val.t),
      .dec_in     (b_u),
      .digit      (tens),
      .borrow_out (b_t)
   );

   bcd_down_digit u_hundreds (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val.h),
      .dec_in     (b_t),
      .digit      (hundreds),
      .borrow_out (b_h)
   );

`ifdef COUNTDOWN_ALARM_BLINK_EN
   localparam int HALF = PRESCALE / 2;

   logic [PW-1:0] blink;
   logic          blink_flip;

   assign blink_flip = (state == EXPIRED) && (blink == PW'(HALF - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         blink <= '0;
      end else if (state != EXPIRED || blink_flip) begin
         blink <= '0;
      end else begin
         blink <= blink + PW'(1);
      end
   end
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         presc   <= '0;
         preset  <= '0;
         RUNNING <= 1'b0;
         ALARM   <= 1'b0;
      end else if (LOAD) begin
         state   <= IDLE;
         presc   <= '0;
         preset  <= {bcd_clamp(LOAD_HUNDREDS),
                     bcd_clamp(LOAD_TENS),
                     bcd_clamp(LOAD_UNITS)};
         RUNNING <= 1'b0;
         ALARM   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               presc <= '0;
               if (START_STOP && cnt_nz) begin
                  state   <= RUN;
                  RUNNING <= 1'b1;
               end
            end
            RUN: begin
               presc <= presc_end ? '0 : presc + PW'(1);
               // The tick completes first; a pause then holds that value.
               if (expire) begin
                  state   <= EXPIRED;
                  RUNNING <= 1'b0;
                  ALARM   <= 1'b1;
               end else if (START_STOP) begin
                  state   <= PAUSE;
                  RUNNING <= 1'b0;
               end
            end
            PAUSE: begin
               if (START_STOP) begin
                  state   <= RUN;
                  RUNNING <= 1'b1;
               end
            end
            EXPIRED: begin
               presc <= '0;
               if (START_STOP) begin
                  state <= IDLE;
                  ALARM <= 1'b0;
               end
`ifdef COUNTDOWN_ALARM_BLINK_EN
               else if (blink_flip) begin
                  ALARM <= ~ALARM;
               end
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter PRESCALE, default 100000000, SHALL set the clock cycles per one-count decrement (1 Hz at 100 MHz); the legal minimum is 2.
REQ-002 Port CLK, input, 1, SHALL be the single system clock; all state changes on its rising edge.
REQ-003 Port RESET_N, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port START_STOP, input, 1, SHALL be a single-cycle, already-debounced run/pause request pulse.
REQ-005 Port LOAD, input, 1, SHALL be a single-cycle, already-debounced preset-load pulse.
REQ-006 Ports LOAD_UNITS, LOAD_TENS, LOAD_HUNDREDS, input, 4 each, SHALL carry the BCD preset sampled on LOAD.
REQ-007 Ports units, tens, hundreds, output, 4 each, SHALL carry the registered BCD count; they feed the three low digits of the 7-segment display stage.
REQ-008 Port RUNNING, output, 1, SHALL be high exactly while the state is RUN.
REQ-009 Port ALARM, output, 1, SHALL signal expiry.

Function
REQ-010 The block SHALL implement the states IDLE, RUN, PAUSE and EXPIRED.
REQ-011 LOAD SHALL, from any state, set the preset register and the count to the LOAD_* values and enter IDLE; any digit above 9 SHALL be clamped to 9.
REQ-012 START_STOP SHALL move IDLE->RUN when the count is non-zero and be ignored in IDLE when the count is 000.
REQ-013 START_STOP SHALL move RUN->PAUSE and PAUSE->RUN.
REQ-014 START_STOP in EXPIRED SHALL restore the count from the preset register and enter IDLE.
REQ-015 LOAD and START_STOP asserted in the same cycle SHALL act as LOAD only.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 only in RUN, hold its value in PAUSE, and clear in IDLE and EXPIRED.
REQ-017 A tick SHALL occur in the cycle the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
REQ-018 On a tick the count SHALL decrement by one in BCD: a units 0 becomes 9 and borrows from tens, and a tens 0 becomes 9 and borrows from hundreds.
REQ-019 Outputs SHALL update on the clock edge that ends the tick cycle, i.e. one register stage with no further latency.
REQ-020 A tick that yields 000 SHALL enter EXPIRED on the same edge; the count SHALL never wrap below 000.
REQ-021 A START_STOP arriving in a tick cycle SHALL let the tick decrement complete and then take effect, so RUN->PAUSE holds the decremented value.
REQ-022 ALARM SHALL be low in every state other than EXPIRED.

Reset
REQ-023 On RESET_N low the block SHALL asynchronously clear the state to IDLE, and units, tens, hundreds, the preset, the prescaler, RUNNING and ALARM to 0.
REQ-024 A reset asserted mid-count SHALL discard the count with no resume.
REQ-025 Reset release SHALL be synchronised by the system's reset bridge, not inside this block.

Configuration
REQ-026 With macro COUNTDOWN_ALARM_BLINK_EN defined, ALARM SHALL toggle every PRESCALE/2 cycles in EXPIRED, starting high on entry.
REQ-027 With COUNTDOWN_ALARM_BLINK_EN undefined, ALARM SHALL be steady high in EXPIRED and no blink counter logic SHALL be synthesised.

Structure
REQ-028 Package countdown_pkg SHALL hold the state enum (IDLE, RUN, PAUSE, EXPIRED), the 4-bit BCD digit type and the BCD_MAX = 9 constant.
REQ-029 Sub-module bcd_down_digit SHALL implement one decade: inputs dec_in and load, outputs digit and borrow_out; it is instantiated three times and chained.

Verification (PRESCALE = 4)
REQ-030 The bench SHALL load 012, pulse START_STOP and observe the sequence 012, 011, 010, 009 at 4-cycle spacing, with 010->009 exercising the tens borrow.
REQ-031 The bench SHALL load 100, run one tick and require 099; it SHALL then load 001, run and require 000, EXPIRED and ALARM=1 on the same edge, after which the count stays at 000.
REQ-032 The bench SHALL run from 050, pulse START_STOP after 2 prescaler cycles, wait 20 cycles and require the count to hold with RUNNING=0; after resume, the next decrement SHALL arrive 2 cycles later.
REQ-033 The bench SHALL pulse LOAD and START_STOP together while in RUN with LOAD value 5,12,3 and require the count to become 395 with the state IDLE.
REQ-034 The bench SHALL pulse START_STOP at count 000 in IDLE and require no change; from EXPIRED after a 007 preset, START_STOP SHALL yield 007 in IDLE.
REQ-035 The bench SHALL assert RESET_N low mid-run, between clock edges, and require all outputs at 0 immediately; with COUNTDOWN_ALARM_BLINK_EN defined it SHALL check that ALARM toggles every 2 cycles in EXPIRED.
